// File: rtl/mux_pkg.sv
// Shared constants for the round-robin bus multiplexer.
// Arbitration mode encodings.
package mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans req upward from rr_ptr, wrapping.
// The pointer moves past the winner only when advance is set.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  localparam logic [SEL_W:0]   CH   = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W:0]   idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      if (idx >= CH) idx = idx - CH;
      if (!found && req[idx[SEL_W-1:0]]) begin
        found                  = 1'b1;
        grant[idx[SEL_W-1:0]]  = 1'b1;
        grant_idx              = idx[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rr_bus_mux.sv
// Registered N-channel bus mux with valid/ready handshakes,
// fixed-select or round-robin arbitration.
module rr_bus_mux
  import mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  logic                can_load;
  logic                sel_ok;
  logic                xfer;
  logic                advance;
  logic [CHANNELS-1:0] rr_grant;
  logic [CHANNELS-1:0] fix_grant;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    rr_idx;
  logic [SEL_W-1:0]    gidx;

  assign can_load  = !out_valid || out_ready;
  assign sel_ok    = {1'b0, sel} < (SEL_W+1)'(CHANNELS);
  assign fix_grant = sel_ok ? (in_valid & (CHANNELS'(1) << sel)) : '0;
  assign grant     = (mode == MODE_RR) ? rr_grant : fix_grant;
  assign gidx      = (mode == MODE_RR) ? rr_idx : sel;
  assign in_ready  = grant & {CHANNELS{can_load}};
  assign xfer      = |in_ready;
  assign advance   = xfer && (mode == MODE_RR);

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (advance),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // Load and drain can coincide, giving one beat per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gidx*WIDTH +: WIDTH];
      out_chan  <= gidx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_bus_mux.sv
// Self-checking bench for rr_bus_mux with a behavioural model.
module tb_rr_bus_mux;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         mode = 1'b0;
  logic [3:0]   sel = '0;
  logic [15:0]  in_valid = '0;
  logic [127:0] in_data = '0;
  logic [15:0]  in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [3:0]   out_chan;
  logic         out_ready = 1'b1;

  logic         b_mode = 1'b0;
  logic [3:0]   b_sel = '0;
  logic [9:0]   b_valid = '0;
  logic [79:0]  b_data = '0;
  logic [9:0]   b_in_ready;
  logic         b_out_valid;
  logic [7:0]   b_out_data;
  logic [3:0]   b_out_chan;
  logic         b_out_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  bit       m_valid;
  bit [7:0] m_data;
  int       m_chan;
  int       m_ptr;

  always #5 clk = ~clk;

  rr_bus_mux dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_chan(out_chan),
    .out_ready(out_ready)
  );

  rr_bus_mux #(.WIDTH(8), .CHANNELS(10)) dut_b (
    .clk(clk), .rst(rst), .mode(b_mode), .sel(b_sel),
    .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_chan(b_out_chan),
    .out_ready(b_out_ready)
  );

  function automatic int ref_pick(bit md, int s, logic [15:0] v, int ptr);
    if (!md) return (s < 16 && v[s]) ? s : -1;
    for (int k = 0; k < 16; k++) begin
      if (v[(ptr + k) % 16]) return (ptr + k) % 16;
    end
    return -1;
  endfunction

  function automatic logic [15:0] ref_ready();
    int p;
    p = ref_pick(mode, int'(sel), in_valid, m_ptr);
    if (p >= 0 && (!m_valid || out_ready)) return 16'(1) << p;
    return '0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0;
  endtask

  task automatic tick();
    int p;
    bit cl;
    p  = ref_pick(mode, int'(sel), in_valid, m_ptr);
    cl = !m_valid || out_ready;
    @(posedge clk);
    if (p >= 0 && cl) begin
      m_valid = 1;
      m_data  = in_data[p*8 +: 8];
      m_chan  = p;
      if (mode) m_ptr = (p + 1) % 16;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'(i * 8'h11);
    for (int i = 0; i < 10; i++) b_data[i*8 +: 8] = 8'(i * 8'h11);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 4'h0) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%h c=%0d want 0/00/0",
               out_valid, out_data, out_chan);
    end
    checks++;
    if (in_ready !== 16'h0) begin
      failures++;
      $display("FAIL reset_ready got %h want 0000", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fixed_sweep();
    do_reset();
    load_pattern();
    mode = 1'b0;
    out_ready = 1'b1;
    in_valid = 16'hffff;
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s);
      #1;
      checks++;
      if (in_ready !== (16'(1) << s)) begin
        failures++;
        $display("FAIL sweep_ready sel=%0d got %h want %h", s, in_ready, 16'(1) << s);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(s * 8'h11) || out_chan !== 4'(s)) begin
        failures++;
        $display("FAIL sweep_out sel=%0d got v=%b d=%h c=%0d want 1/%h/%0d",
                 s, out_valid, out_data, out_chan, 8'(s * 8'h11), s);
      end
    end
  endtask

  task automatic test_rr_fairness();
    int exp_seq[6] = '{2, 5, 15, 2, 5, 15};
    do_reset();
    load_pattern();
    mode = 1'b1;
    out_ready = 1'b1;
    in_valid = 16'h8024;
    foreach (exp_seq[i]) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_chan !== 4'(exp_seq[i])) begin
        failures++;
        $display("FAIL rr_seq step=%0d got v=%b c=%0d want 1/%0d",
                 i, out_valid, out_chan, exp_seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    load_pattern();
    mode = 1'b1;
    out_ready = 1'b1;
    in_valid = 16'h8024;
    tick();
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 16'h0) begin
        failures++;
        $display("FAIL bp_ready cyc=%0d got %h want 0000", c, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h55 || out_chan !== 4'd5) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%h c=%0d want 1/55/5",
                 c, out_valid, out_data, out_chan);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 16'h8000) begin
      failures++;
      $display("FAIL bp_release_ready got %h want 8000", in_ready);
    end
    tick();
    checks++;
    if (out_chan !== 4'd15 || out_data !== 8'hff) begin
      failures++;
      $display("FAIL bp_release got c=%0d d=%h want 15/ff", out_chan, out_data);
    end
  endtask

  task automatic test_invalid_sel();
    load_pattern();
    b_mode = 1'b0;
    b_sel = 4'd1;
    b_valid = 10'h3ff;
    b_out_ready = 1'b1;
    tick();
    checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== 8'h11) begin
      failures++;
      $display("FAIL badsel_prime got v=%b d=%h want 1/11", b_out_valid, b_out_data);
    end
    b_sel = 4'd12;
    #1;
    checks++;
    if (b_in_ready !== 10'h0) begin
      failures++;
      $display("FAIL badsel_ready got %h want 000", b_in_ready);
    end
    tick();
    checks++;
    if (b_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL badsel_drain got v=%b want 0", b_out_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    load_pattern();
    mode = 1'b1;
    out_ready = 1'b1;
    in_valid = 16'hffff;
    tick();
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 4'h0) begin
      failures++;
      $display("FAIL async_rst got v=%b d=%h c=%0d want 0/00/0",
               out_valid, out_data, out_chan);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 16'h0202;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 4'd1) begin
      failures++;
      $display("FAIL async_rst_resume got v=%b c=%0d want 1/1", out_valid, out_chan);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    load_pattern();
    mode = 1'b1;
    out_ready = 1'b1;
    in_valid = 16'h0020;
    tick();
    in_valid = 16'hffff;
    mode = 1'b0;
    sel = 4'd3;
    tick();
    checks++;
    if (out_chan !== 4'd3 || out_data !== 8'h33) begin
      failures++;
      $display("FAIL mode_fixed got c=%0d d=%h want 3/33", out_chan, out_data);
    end
    mode = 1'b1;
    tick();
    checks++;
    if (out_chan !== 4'd6 || out_data !== 8'h66) begin
      failures++;
      $display("FAIL mode_rr_resume got c=%0d d=%h want 6/66", out_chan, out_data);
    end
  endtask

  task automatic test_random();
    logic [15:0] er;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = $urandom;
      in_valid  = 16'($urandom) & 16'($urandom);
      mode      = 1'($urandom);
      sel       = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      er = ref_ready();
      checks++;
      if (in_ready !== er) begin
        failures++;
        $display("FAIL rand_ready n=%0d got %h want %h", n, in_ready, er);
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_chan !== 4'(m_chan)) begin
        failures++;
        $display("FAIL rand_out n=%0d got v=%b d=%h c=%0d want %b/%h/%0d",
                 n, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fixed_sweep();
    test_rr_fairness();
    test_backpressure();
    test_invalid_sel();
    test_async_reset();
    test_mode_switch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
